escalonador_conversor_bcd: RTL and testbench
============================================

Name: escalonador_conversor_bcd

Overview:
- Controller that shares one sequential binary-to-BCD (shift-and-add-3) engine among up to 4 requesters, e.g. operand A, operand B and the ALU result of the 4-bit calculator.
- Arbitrates round-robin and latches the winner's 4-bit value.
- Sequences the adjust/shift steps, then returns tens/units digits with a one-cycle ack to the winner.
- Sits between the calculator datapath and the 7-segment display stage.

Parameters:
NUM_REQ, 3, number of requesters; legal range 2..4.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  request per requester; hold high until ack
dados  in  4*NUM_REQ  binary value; requester i on bits [4i+3:4i]
ack  out  NUM_REQ  one-hot, one-cycle completion pulse to the served requester
concessao  out  NUM_REQ  one-hot grant; nonzero while ocupado
ocupado  out  1  high whenever the state is not OCIOSO
valido  out  1  high for the same cycle as ack
origem  out  2  index of the requester whose result is on bcd_*
bcd_dezena  out  4  tens digit (0..1)
bcd_unidade  out  4  units digit (0..9)

Behaviour:
- Reset (async, any state):
  - State goes to OCIOSO.
  - ack, concessao, ocupado, valido, origem, bcd_dezena and bcd_unidade go to 0.
  - Internal shift registers go to 0.
  - Round-robin pointer ultimo goes to NUM_REQ-1, so req[0] has top priority.
- States: OCIOSO, AJUSTA, DESLOCA, FIM.
- OCIOSO, at a clock edge with any req bit high:
  - Grant g is the first requester with req set, searching from ultimo+1 upward mod NUM_REQ.
  - Latch dados[4g+3:4g] into shift register bin.
  - Clear dez and uni; set contador=3.
  - Set concessao to one-hot(g); go to AJUSTA.
  - With no request, stay in OCIOSO.
- AJUSTA, one cycle:
  - If dez>=5 then dez=dez+3.
  - If uni>=5 then uni=uni+3.
  - Go to DESLOCA.
- DESLOCA, one cycle:
  - Shift {dez,uni,bin} left by 1 as a single 12-bit register.
  - If contador==0: load bcd_dezena/bcd_unidade from the post-shift dez/uni, set origem=g, and go to FIM.
  - Otherwise decrement contador and go to AJUSTA.
- FIM, one cycle:
  - ack[g]=1 and valido=1; concessao stays one-hot(g).
  - Set ultimo=g; go to OCIOSO.
  - Grant clears on exit.
- Latency:
  - Grant edge T0; final shift at edge T8; ack/valido high between T8 and T9.
  - Earliest next grant is at edge T10.
  - Throughput is 1 conversion per 10 cycles.
- Outputs:
  - bcd_dezena, bcd_unidade and origem hold until the next completion. They are not cleared on entry to OCIOSO.
- Boundary rules:
  - dados is sampled only at the grant edge; later changes are ignored.
  - req dropped mid-conversion: the conversion still completes and ack still pulses.
  - req still high after ack is treated as a new request, ranked behind others by the round-robin pointer.
  - Input 15 gives dez=1, uni=5. Input 0 gives 0/0.
  - Digit nibbles never exceed 4 bits: any nibble is <=9 before its adjust.
  - Simultaneous requests are resolved only by the pointer; no requester waits more than NUM_REQ-1 conversions.
  - req bits at index >= NUM_REQ do not exist.
  - With NUM_REQ<4, origem upper codes are never produced.

Test Plan:
- Reset, then req[1]=1 with dados[7:4]=13 → concessao=3'b010 at T0; ack=3'b010 and valido=1 for exactly one cycle after T8; bcd_dezena=1, bcd_unidade=3, origem=1.
- Sweep 0..15 on requester 0 → (0,0)…(0,9),(1,0)…(1,5). Check the 9→10 boundary and 15 → (1,5).
- req=3'b111 held, values 4, 9, 12 → served in order 0, 1, 2, 0…; results (0,4), (0,9), (1,2); grants 10 cycles apart.
- Grant requester 2 with value 11, change dados to 3 at T3 and drop req at T4 → result still (1,1); ack[2] still pulses.
- Assert reset at T5 of a conversion → all outputs 0 immediately, state OCIOSO. After release, req=3'b011 → requester 0 served first.
- Two back-to-back completions → bcd_* and origem hold their values between them while ocupado=0.

Source files
------------

// File: rtl/escalonador_conversor_bcd.sv
// Shared shift-and-add-3 binary-to-BCD engine, arbitrated round-robin among
// NUM_REQ requesters (2..4); returns tens/units digits with a one-cycle ack.
module escalonador_conversor_bcd #(
  parameter int NUM_REQ = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   dados,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     concessao,
  output logic                   ocupado,
  output logic                   valido,
  output logic [1:0]             origem,
  output logic [3:0]             bcd_dezena,
  output logic [3:0]             bcd_unidade
);

  typedef enum logic [1:0] {OCIOSO, AJUSTA, DESLOCA, FIM} estado_t;

  localparam logic [NUM_REQ-1:0] UM      = 1;
  localparam logic [1:0]         ULT_INI = 2'(NUM_REQ - 1);

  estado_t              estado_q, estado_d;
  logic [1:0]           ultimo_q, ultimo_d;
  logic [1:0]           indice_q, indice_d;
  logic [1:0]           contador_q, contador_d;
  logic [3:0]           bin_q, bin_d;
  logic [3:0]           dez_q, dez_d;
  logic [3:0]           uni_q, uni_d;
  logic [NUM_REQ-1:0]   concessao_q, concessao_d;
  logic [1:0]           origem_q, origem_d;
  logic [3:0]           bcd_dez_q, bcd_dez_d;
  logic [3:0]           bcd_uni_q, bcd_uni_d;
  logic [1:0]           vencedor;
  logic [3:0]           valor_venc;

  // First requester with req set, searching upward from ultimo+1 (mod NUM_REQ).
  function automatic logic [1:0] escolhe(input logic [NUM_REQ-1:0] r,
                                         input logic [1:0] ult);
    int idx;
    escolhe = ult;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ult) + k) % NUM_REQ;
      if (r[idx]) escolhe = 2'(idx);
    end
  endfunction

  assign vencedor   = escolhe(req, ultimo_q);
  assign valor_venc = dados[4*int'(vencedor) +: 4];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado_q <= OCIOSO;
    else       estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO:  if (|req) estado_d = AJUSTA;
      AJUSTA:  estado_d = DESLOCA;
      DESLOCA: estado_d = (contador_q == 2'd0) ? FIM : AJUSTA;
      FIM:     estado_d = OCIOSO;
      default: estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    ocupado = (estado_q != OCIOSO);
    valido  = (estado_q == FIM);
    ack     = (estado_q == FIM) ? concessao_q : '0;
  end

  always_comb begin
    ultimo_d    = ultimo_q;
    indice_d    = indice_q;
    contador_d  = contador_q;
    bin_d       = bin_q;
    dez_d       = dez_q;
    uni_d       = uni_q;
    concessao_d = concessao_q;
    origem_d    = origem_q;
    bcd_dez_d   = bcd_dez_q;
    bcd_uni_d   = bcd_uni_q;
    case (estado_q)
      OCIOSO: begin
        if (|req) begin
          indice_d    = vencedor;
          bin_d       = valor_venc;
          dez_d       = 4'd0;
          uni_d       = 4'd0;
          contador_d  = 2'd3;
          concessao_d = UM << vencedor;
        end
      end
      AJUSTA: begin
        if (dez_q >= 4'd5) dez_d = dez_q + 4'd3;
        if (uni_q >= 4'd5) uni_d = uni_q + 4'd3;
      end
      DESLOCA: begin
        {dez_d, uni_d, bin_d} = {dez_q, uni_q, bin_q} << 1;
        if (contador_q == 2'd0) begin
          bcd_dez_d = dez_d;
          bcd_uni_d = uni_d;
          origem_d  = indice_q;
        end else begin
          contador_d = contador_q - 2'd1;
        end
      end
      FIM: begin
        ultimo_d    = indice_q;
        concessao_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ultimo_q    <= ULT_INI;
      indice_q    <= 2'd0;
      contador_q  <= 2'd0;
      bin_q       <= 4'd0;
      dez_q       <= 4'd0;
      uni_q       <= 4'd0;
      concessao_q <= '0;
      origem_q    <= 2'd0;
      bcd_dez_q   <= 4'd0;
      bcd_uni_q   <= 4'd0;
    end else begin
      ultimo_q    <= ultimo_d;
      indice_q    <= indice_d;
      contador_q  <= contador_d;
      bin_q       <= bin_d;
      dez_q       <= dez_d;
      uni_q       <= uni_d;
      concessao_q <= concessao_d;
      origem_q    <= origem_d;
      bcd_dez_q   <= bcd_dez_d;
      bcd_uni_q   <= bcd_uni_d;
    end
  end

  assign concessao   = concessao_q;
  assign origem      = origem_q;
  assign bcd_dezena  = bcd_dez_q;
  assign bcd_unidade = bcd_uni_q;

endmodule

// File: tb/tb_escalonador_conversor_bcd.sv
// Directed bench for the shared BCD converter scheduler with NUM_REQ=3.
module tb_escalonador_conversor_bcd;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [11:0] dados;
  logic [2:0]  ack;
  logic [2:0]  concessao;
  logic        ocupado;
  logic        valido;
  logic [1:0]  origem;
  logic [3:0]  bcd_dezena;
  logic [3:0]  bcd_unidade;

  int checks = 0;
  int errors = 0;

  escalonador_conversor_bcd #(.NUM_REQ(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .dados       (dados),
    .ack         (ack),
    .concessao   (concessao),
    .ocupado     (ocupado),
    .valido      (valido),
    .origem      (origem),
    .bcd_dezena  (bcd_dezena),
    .bcd_unidade (bcd_unidade)
  );

  always #5 clock = ~clock;

  task automatic test_reset;
    reset = 1'b1; req = 3'b000; dados = 12'h000;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (ack !== 3'b000) begin errors++; $display("FAIL reset_ack got %b want 000", ack); end
    checks++; if (concessao !== 3'b000) begin errors++; $display("FAIL reset_concessao got %b want 000", concessao); end
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL reset_ocupado got %b want 0", ocupado); end
    checks++; if (valido !== 1'b0) begin errors++; $display("FAIL reset_valido got %b want 0", valido); end
    checks++; if ({origem, bcd_dezena, bcd_unidade} !== 10'd0) begin errors++; $display("FAIL reset_digits got %0d/%0d/%0d want 0/0/0", origem, bcd_dezena, bcd_unidade); end
    @(negedge clock) reset = 1'b0;
    @(posedge clock); #1;
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL idle_no_req ocupado got %b want 0", ocupado); end
  endtask

  task automatic test_basic;
    @(negedge clock); req = 3'b010; dados = 12'h0D0;
    @(posedge clock); #1;
    checks++; if (concessao !== 3'b010) begin errors++; $display("FAIL basic_grant got %b want 010", concessao); end
    checks++; if (ocupado !== 1'b1) begin errors++; $display("FAIL basic_ocupado got %b want 1", ocupado); end
    for (int c = 1; c <= 7; c++) begin
      @(posedge clock); #1;
      checks++; if ({ack, valido} !== 4'b0000) begin errors++; $display("FAIL basic_early_ack T%0d got %b/%b want 000/0", c, ack, valido); end
    end
    @(posedge clock); #1;
    checks++; if (ack !== 3'b010) begin errors++; $display("FAIL basic_ack got %b want 010", ack); end
    checks++; if (valido !== 1'b1) begin errors++; $display("FAIL basic_valido got %b want 1", valido); end
    checks++; if ({bcd_dezena, bcd_unidade} !== 8'h13) begin errors++; $display("FAIL basic_digits got %0d/%0d want 1/3", bcd_dezena, bcd_unidade); end
    checks++; if (origem !== 2'd1) begin errors++; $display("FAIL basic_origem got %0d want 1", origem); end
    @(negedge clock) req = 3'b000;
    @(posedge clock); #1;
    checks++; if ({ack, valido} !== 4'b0000) begin errors++; $display("FAIL basic_ack_one_cycle got %b/%b want 000/0", ack, valido); end
    checks++; if ({concessao, ocupado} !== 4'b0000) begin errors++; $display("FAIL basic_release got %b/%b want 000/0", concessao, ocupado); end
  endtask

  task automatic test_sweep;
    int exp_d [16] = '{0,0,0,0,0,0,0,0,0,0,1,1,1,1,1,1};
    int exp_u [16] = '{0,1,2,3,4,5,6,7,8,9,0,1,2,3,4,5};
    logic [3:0] v;
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      @(negedge clock); req = 3'b001; dados = {8'h00, v};
      @(posedge clock); #1;
      checks++; if (concessao !== 3'b001) begin errors++; $display("FAIL sweep_grant val %0d got %b want 001", i, concessao); end
      repeat (7) @(posedge clock);
      @(posedge clock); #1;
      checks++;
      if (bcd_dezena !== 4'(exp_d[i]) || bcd_unidade !== 4'(exp_u[i]) || ack !== 3'b001) begin
        errors++;
        $display("FAIL sweep val %0d got %0d/%0d ack %b want %0d/%0d ack 001", i, bcd_dezena, bcd_unidade, ack, exp_d[i], exp_u[i]);
      end
      @(negedge clock) req = 3'b000;
      @(posedge clock);
    end
  endtask

  task automatic test_round_robin;
    logic [2:0] exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
    logic [7:0] exp_v [4] = '{8'h04, 8'h09, 8'h12, 8'h04};
    logic [1:0] exp_o [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    @(negedge clock); reset = 1'b1; req = 3'b000;
    @(negedge clock); reset = 1'b0; req = 3'b111; dados = {4'd12, 4'd9, 4'd4};
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      checks++; if (concessao !== exp_g[k]) begin errors++; $display("FAIL rr_grant %0d got %b want %b", k, concessao, exp_g[k]); end
      repeat (7) @(posedge clock);
      @(posedge clock); #1;
      checks++; if (ack !== exp_g[k]) begin errors++; $display("FAIL rr_ack %0d got %b want %b", k, ack, exp_g[k]); end
      checks++;
      if ({bcd_dezena, bcd_unidade} !== exp_v[k] || origem !== exp_o[k]) begin
        errors++;
        $display("FAIL rr_result %0d got %0d/%0d org %0d want %h org %0d", k, bcd_dezena, bcd_unidade, origem, exp_v[k], exp_o[k]);
      end
      @(posedge clock); #1;
      checks++; if (concessao !== 3'b000) begin errors++; $display("FAIL rr_gap %0d got %b want 000", k, concessao); end
    end
    @(negedge clock) req = 3'b000;
    @(posedge clock);
  endtask

  task automatic test_boundary;
    @(negedge clock); req = 3'b100; dados = {4'd11, 4'd0, 4'd0};
    @(posedge clock); #1;
    checks++; if (concessao !== 3'b100) begin errors++; $display("FAIL bnd_grant got %b want 100", concessao); end
    repeat (2) @(posedge clock);
    @(posedge clock); #2 dados = {4'd3, 4'd0, 4'd0};
    @(posedge clock); #2 req = 3'b000;
    repeat (3) @(posedge clock);
    @(posedge clock); #1;
    checks++; if (ack !== 3'b100 || valido !== 1'b1) begin errors++; $display("FAIL bnd_ack got %b/%b want 100/1", ack, valido); end
    checks++; if ({bcd_dezena, bcd_unidade} !== 8'h11 || origem !== 2'd2) begin errors++; $display("FAIL bnd_result got %0d/%0d org %0d want 1/1 org 2", bcd_dezena, bcd_unidade, origem); end
    @(posedge clock); #1;
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL bnd_idle got %b want 0", ocupado); end
  endtask

  task automatic test_reset_mid;
    @(negedge clock); req = 3'b001; dados = {4'd0, 4'd0, 4'd7};
    @(posedge clock); #1;
    checks++; if (concessao !== 3'b001) begin errors++; $display("FAIL rmid_grant got %b want 001", concessao); end
    repeat (5) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checks++; if ({ack, concessao, ocupado, valido} !== 8'd0) begin errors++; $display("FAIL rmid_ctrl got %b/%b/%b/%b want 0", ack, concessao, ocupado, valido); end
    checks++; if ({origem, bcd_dezena, bcd_unidade} !== 10'd0) begin errors++; $display("FAIL rmid_digits got %0d/%0d/%0d want 0/0/0", origem, bcd_dezena, bcd_unidade); end
    @(negedge clock); reset = 1'b0; req = 3'b011; dados = {4'd0, 4'd6, 4'd5};
    @(posedge clock); #1;
    checks++; if (concessao !== 3'b001) begin errors++; $display("FAIL rmid_priority got %b want 001", concessao); end
    repeat (7) @(posedge clock);
    @(posedge clock); #1;
    checks++; if (ack !== 3'b001 || {bcd_dezena, bcd_unidade} !== 8'h05 || origem !== 2'd0) begin
      errors++; $display("FAIL rmid_result got ack %b %0d/%0d org %0d want 001 0/5 org 0", ack, bcd_dezena, bcd_unidade, origem);
    end
    @(negedge clock) req = 3'b000;
    @(posedge clock); #1;
    checks++; if (ocupado !== 1'b0) begin errors++; $display("FAIL rmid_idle got %b want 0", ocupado); end
  endtask

  task automatic test_back_to_back;
    @(negedge clock); req = 3'b010; dados = {4'd0, 4'd14, 4'd0};
    @(posedge clock); #1;
    checks++; if (concessao !== 3'b010) begin errors++; $display("FAIL b2b_grant1 got %b want 010", concessao); end
    repeat (7) @(posedge clock);
    @(posedge clock); #1;
    checks++; if (ack !== 3'b010 || {bcd_dezena, bcd_unidade} !== 8'h14 || origem !== 2'd1) begin
      errors++; $display("FAIL b2b_first got ack %b %0d/%0d org %0d want 010 1/4 org 1", ack, bcd_dezena, bcd_unidade, origem);
    end
    @(negedge clock) req = 3'b000;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      checks++;
      if (ocupado !== 1'b0 || {bcd_dezena, bcd_unidade} !== 8'h14 || origem !== 2'd1) begin
        errors++; $display("FAIL b2b_hold %0d got ocp %b %0d/%0d org %0d want 0 1/4 org 1", c, ocupado, bcd_dezena, bcd_unidade, origem);
      end
    end
    @(negedge clock); req = 3'b100; dados = {4'd8, 4'd0, 4'd0};
    @(posedge clock); #1;
    checks++; if (concessao !== 3'b100) begin errors++; $display("FAIL b2b_grant2 got %b want 100", concessao); end
    repeat (6) @(posedge clock);
    @(posedge clock); #1;
    checks++; if ({bcd_dezena, bcd_unidade} !== 8'h14 || origem !== 2'd1) begin
      errors++; $display("FAIL b2b_hold_busy got %0d/%0d org %0d want 1/4 org 1", bcd_dezena, bcd_unidade, origem);
    end
    @(posedge clock); #1;
    checks++; if (ack !== 3'b100 || {bcd_dezena, bcd_unidade} !== 8'h08 || origem !== 2'd2) begin
      errors++; $display("FAIL b2b_second got ack %b %0d/%0d org %0d want 100 0/8 org 2", ack, bcd_dezena, bcd_unidade, origem);
    end
    @(negedge clock) req = 3'b000;
    @(posedge clock); #1;
    checks++; if (ocupado !== 1'b0 || {bcd_dezena, bcd_unidade} !== 8'h08) begin
      errors++; $display("FAIL b2b_final got ocp %b %0d/%0d want 0 0/8", ocupado, bcd_dezena, bcd_unidade);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_round_robin();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
